// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Lets the instruction-fetch port and the load/store port share one single-port,
// word-addressed memory. The data port has priority. A starvation counter makes
// sure a pending fetch is granted after STARVE_MAX data grants in a row. Read
// data comes back RD_LAT cycles after the grant. A new access can be granted in
// the same cycle that an earlier read returns.
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    localparam int CW = $clog2(RD_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    // Reject parameter values that the latency counter and starvation logic cannot handle.
    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
            $error("mem_port_arbiter: RD_LAT must be in 1..4");
        end
        if (STARVE_MAX < 1) begin : g_bad_starve_max
            $error("mem_port_arbiter: STARVE_MAX must be at least 1");
        end
    endgenerate

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          owner_is_d_q, owner_is_d_d;   // 1: the data port owns the outstanding read
    logic [CW-1:0] cnt_q, cnt_d;                 // cycles left until the outstanding read returns
    logic [SW-1:0] starve_q, starve_d;           // data grants in a row while a fetch waited

    logic          rd_return;   // outstanding read returns in this cycle
    logic          arb_open;    // a new access may be granted in this cycle
    logic          if_starved;  // fetch has waited long enough to beat the data port
    logic          win_d;
    logic          win_if;
    logic          rd_grant;    // the granted access is a read

    // Pick the winner. Arbitration is open when idle, or when the outstanding read returns in this cycle.
    always_comb begin
        rd_return  = (state_q == RD_WAIT) && (cnt_q == CW'(1));
        arb_open   = (state_q == IDLE) || rd_return;
        if_starved = if_req && (starve_q == SW'(STARVE_MAX));
        win_d      = arb_open && d_req && !if_starved;
        win_if     = arb_open && if_req && !win_d;
        rd_grant   = win_if || (win_d && !d_we);
    end

    // Next state: latency countdown, read-owner capture, starvation bookkeeping.
    always_comb begin
        state_d      = state_q;
        owner_is_d_d = owner_is_d_q;
        cnt_d        = cnt_q;
        starve_d     = starve_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
            end
            RD_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (rd_return) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A read grant in the return cycle overrides the return to IDLE.
        // A store grant completes at once and leaves the state as decided above.
        if (rd_grant) begin
            state_d      = RD_WAIT;
            cnt_d        = CW'(RD_LAT);
            owner_is_d_d = win_d;
        end

        // The count only grows while a fetch is actually waiting. It saturates at STARVE_MAX.
        if (!if_req || win_if) begin
            starve_d = '0;
        end else if (win_d && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // State registers with synchronous active-low reset. Reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_is_d_q <= 1'b0;
            cnt_q        <= '0;
            starve_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_is_d_q <= owner_is_d_d;
            cnt_q        <= cnt_d;
            starve_q     <= starve_d;
        end
    end

    // Drive the port and memory outputs. Every output is held at zero while reset is asserted.
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;

        if (reset) begin
            if_gnt = win_if;
            d_gnt  = win_d;
            busy   = (state_q == RD_WAIT);

            if (win_d) begin
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end else if (win_if) begin
                mem_en    = 1'b1;
                mem_addr  = if_addr;
                mem_wdata = d_wdata;
            end

            if (rd_return) begin
                if (owner_is_d_q) begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_rdata;
                end else begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. It runs three instances, with RD_LAT = 1, 2 and 3,
// and each instance has its own behavioural memory. The stimulus queues the
// expected grants and read data. A negedge monitor checks every DUT output of
// every instance against those queues.
module tb_mem_port_arbiter;

    localparam int N = 3;

    logic clk;

    logic        reset_n   [N];
    logic        if_req    [N];
    logic [9:0]  if_addr   [N];
    logic        if_gnt    [N];
    logic        if_rvalid [N];
    logic [31:0] if_rdata  [N];
    logic        d_req     [N];
    logic        d_we      [N];
    logic [9:0]  d_addr    [N];
    logic [31:0] d_wdata   [N];
    logic        d_gnt     [N];
    logic        d_rvalid  [N];
    logic [31:0] d_rdata   [N];
    logic        mem_en    [N];
    logic        mem_we    [N];
    logic [9:0]  mem_addr  [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];
    logic        busy      [N];

    typedef struct {
        int          at;      // cycle in which the grant is expected
        bit          is_d;
        logic [9:0]  addr;
        bit          we;
        logic [31:0] wdata;
        logic [31:0] rdata;   // expected read data (ignored for stores)
    } gnt_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        int          due;
    } rd_t;

    gnt_t gq [N][$];
    rd_t  rq [N][$];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit final_req = 1'b0;
    bit final_done = 1'b0;

    // Power-on memory contents. Address 4 holds an ADDI instruction word.
    function automatic logic [31:0] pat(input logic [9:0] a);
        if (a == 10'h004) return 32'h0050_0093;
        return {12'h5A5, 10'h000, a};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_inst
            logic [31:0] mem  [1024];
            logic [31:0] pipe [gi+1];

            initial begin
                for (int a = 0; a < 1024; a++) mem[a] <= pat(10'(a));
                for (int j = 0; j <= gi; j++) pipe[j] <= 32'h0;
            end

            // Memory with a read latency of gi+1 cycles. Cycles with no read return a junk value.
            always @(posedge clk) begin
                if (mem_en[gi] && mem_we[gi]) mem[mem_addr[gi]] <= mem_wdata[gi];
                pipe[0] <= (mem_en[gi] && !mem_we[gi]) ? mem[mem_addr[gi]] : 32'hBAD0_BAD0;
                for (int j = 1; j <= gi; j++) pipe[j] <= pipe[j-1];
            end

            assign mem_rdata[gi] = pipe[gi];

            mem_port_arbiter #(
                .AW(10), .DW(32), .RD_LAT(gi + 1), .STARVE_MAX(4)
            ) u_dut (
                .clk(clk), .reset(reset_n[gi]),
                .if_req(if_req[gi]), .if_addr(if_addr[gi]), .if_gnt(if_gnt[gi]),
                .if_rvalid(if_rvalid[gi]), .if_rdata(if_rdata[gi]),
                .d_req(d_req[gi]), .d_we(d_we[gi]), .d_addr(d_addr[gi]), .d_wdata(d_wdata[gi]),
                .d_gnt(d_gnt[gi]), .d_rvalid(d_rvalid[gi]), .d_rdata(d_rdata[gi]),
                .mem_en(mem_en[gi]), .mem_we(mem_we[gi]), .mem_addr(mem_addr[gi]),
                .mem_wdata(mem_wdata[gi]), .mem_rdata(mem_rdata[gi]),
                .busy(busy[gi])
            );
        end
    endgenerate

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_gnt(input int k, input bit is_d, input logic [9:0] a,
                           input bit we, input logic [31:0] wd, input logic [31:0] rd);
        gnt_t g;
        g.at = cyc; g.is_d = is_d; g.addr = a; g.we = we; g.wdata = wd; g.rdata = rd;
        gq[k].push_back(g);
    endtask

    gnt_t mg;
    rd_t  mr;
    rd_t  nr;
    bit   exp_rv;
    bit   exp_g;

    // Monitor and scoreboard. It compares all outputs of every instance at each negedge.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!reset_n[k]) begin
                chk($sformatf("inst%0d reset ctl", k),
                    {57'b0, if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], mem_en[k], mem_we[k], busy[k]}, 64'h0);
                chk($sformatf("inst%0d reset data", k),
                    {32'b0, if_rdata[k] | d_rdata[k] | mem_wdata[k] | {22'b0, mem_addr[k]}}, 64'h0);
                rq[k].delete();
            end else begin
                chk($sformatf("inst%0d busy", k), {63'b0, busy[k]}, {63'b0, rq[k].size() > 0});

                exp_rv = (rq[k].size() > 0) && (rq[k][0].due == cyc);
                if (exp_rv) begin
                    mr = rq[k].pop_front();
                    chk($sformatf("inst%0d if_rvalid", k), {63'b0, if_rvalid[k]}, {63'b0, !mr.is_d});
                    chk($sformatf("inst%0d d_rvalid", k), {63'b0, d_rvalid[k]}, {63'b0, mr.is_d});
                    chk($sformatf("inst%0d owner rdata", k),
                        {32'b0, mr.is_d ? d_rdata[k] : if_rdata[k]}, {32'b0, mr.rdata});
                    chk($sformatf("inst%0d other rdata", k),
                        {32'b0, mr.is_d ? if_rdata[k] : d_rdata[k]}, 64'h0);
                    $display("inst%0d cyc %0d rvalid %s data=%08h", k, cyc, mr.is_d ? "D " : "IF",
                             mr.is_d ? d_rdata[k] : if_rdata[k]);
                end else begin
                    chk($sformatf("inst%0d no rvalid", k), {62'b0, if_rvalid[k], d_rvalid[k]}, 64'h0);
                end

                exp_g = (gq[k].size() > 0) && (gq[k][0].at == cyc);
                if (exp_g) begin
                    mg = gq[k].pop_front();
                    chk($sformatf("inst%0d gnt", k), {62'b0, if_gnt[k], d_gnt[k]}, {62'b0, !mg.is_d, mg.is_d});
                    chk($sformatf("inst%0d mem_en", k), {63'b0, mem_en[k]}, 64'h1);
                    chk($sformatf("inst%0d mem_we", k), {63'b0, mem_we[k]}, {63'b0, mg.we});
                    chk($sformatf("inst%0d mem_addr", k), {54'b0, mem_addr[k]}, {54'b0, mg.addr});
                    chk($sformatf("inst%0d mem_wdata", k), {32'b0, mem_wdata[k]}, {32'b0, mg.wdata});
                    if (!mg.we) begin
                        nr.is_d = mg.is_d; nr.rdata = mg.rdata; nr.due = cyc + k + 1;
                        rq[k].push_back(nr);
                    end
                    $display("inst%0d cyc %0d grant %s %s addr=%03h wdata=%08h", k, cyc,
                             mg.is_d ? "D " : "IF", mg.we ? "WR" : "RD", mem_addr[k], mem_wdata[k]);
                end else begin
                    chk($sformatf("inst%0d idle strobes", k),
                        {60'b0, if_gnt[k], d_gnt[k], mem_en[k], mem_we[k]}, 64'h0);
                    chk($sformatf("inst%0d idle bus", k), {22'b0, mem_addr[k], mem_wdata[k]}, 64'h0);
                end
            end
        end
        if (final_req && !final_done) begin
            for (int k = 0; k < N; k++) begin
                chk($sformatf("inst%0d grants left", k), 64'(gq[k].size()), 64'h0);
                chk($sformatf("inst%0d reads left", k), 64'(rq[k].size()), 64'h0);
            end
            final_done = 1'b1;
        end
    end

    int di;
    int ii;

    initial begin
        for (int k = 0; k < N; k++) begin
            reset_n[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = '0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
        end

        // Reset with both requests high on instance 0. No grant until release, then D first.
        if_req[0] = 1'b1; if_addr[0] = 10'h020;
        d_req[0]  = 1'b1; d_addr[0]  = 10'h030;
        repeat (3) step();
        for (int k = 0; k < N; k++) reset_n[k] = 1'b1;
        exp_gnt(0, 1'b1, 10'h030, 1'b0, 32'h0, pat(10'h030));
        step();
        d_req[0] = 1'b0;
        exp_gnt(0, 1'b0, 10'h020, 1'b0, 32'h0, pat(10'h020));
        step();
        if_req[0] = 1'b0;
        step();

        // Fetch of the instruction at word 4, RD_LAT=1.
        if_req[0] = 1'b1; if_addr[0] = 10'h004;
        exp_gnt(0, 1'b0, 10'h004, 1'b0, 32'h0, 32'h0050_0093);
        step();
        if_req[0] = 1'b0;
        repeat (2) step();

        // Alternating IF/D reads, one grant per cycle. The last address wraps to the top word.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                if_req[0] = 1'b1; d_req[0] = 1'b0;
                if_addr[0] = (i == 4) ? 10'h3FF : 10'(10'h080 + i);
                exp_gnt(0, 1'b0, if_addr[0], 1'b0, 32'h0, pat(if_addr[0]));
            end else begin
                d_req[0] = 1'b1; if_req[0] = 1'b0;
                d_addr[0] = 10'(10'h0C0 + i);
                exp_gnt(0, 1'b1, d_addr[0], 1'b0, 32'h0, pat(d_addr[0]));
            end
            step();
        end
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        repeat (2) step();

        // Starvation: both ports load continuously, expect D,D,D,D,IF,D,D,D,D,IF.
        // Each address advances only after its port is granted.
        di = 0; ii = 0;
        if_req[0] = 1'b1; d_req[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d_addr[0]  = 10'(10'h100 + di);
            if_addr[0] = 10'(10'h200 + ii);
            if (i % 5 == 4) begin
                exp_gnt(0, 1'b0, if_addr[0], 1'b0, 32'h0, pat(if_addr[0]));
                ii++;
            end else begin
                exp_gnt(0, 1'b1, d_addr[0], 1'b0, 32'h0, pat(d_addr[0]));
                di++;
            end
            step();
        end
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        repeat (2) step();

        // Store then load, RD_LAT=2 (instance 1).
        d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 10'h010; d_wdata[1] = 32'hDEAD_BEEF;
        exp_gnt(1, 1'b1, 10'h010, 1'b1, 32'hDEAD_BEEF, 32'h0);
        step();
        d_we[1] = 1'b0; d_wdata[1] = 32'h0;
        exp_gnt(1, 1'b1, 10'h010, 1'b0, 32'h0, 32'hDEAD_BEEF);
        step();
        d_req[1] = 1'b0;
        repeat (3) step();

        // Back-to-back stores, then a load followed by another load that waits for the return cycle.
        d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 10'h011; d_wdata[1] = 32'h1111_1111;
        exp_gnt(1, 1'b1, 10'h011, 1'b1, 32'h1111_1111, 32'h0);
        step();
        d_addr[1] = 10'h012; d_wdata[1] = 32'h2222_2222;
        exp_gnt(1, 1'b1, 10'h012, 1'b1, 32'h2222_2222, 32'h0);
        step();
        d_we[1] = 1'b0; d_wdata[1] = 32'h0;
        exp_gnt(1, 1'b1, 10'h012, 1'b0, 32'h0, 32'h2222_2222);
        step();
        d_addr[1] = 10'h011;
        step();
        exp_gnt(1, 1'b1, 10'h011, 1'b0, 32'h0, 32'h1111_1111);
        step();
        d_req[1] = 1'b0;
        repeat (3) step();

        // Reset one cycle after a load grant, RD_LAT=3 (instance 2). The load must never return.
        d_req[2] = 1'b1; d_addr[2] = 10'h040;
        exp_gnt(2, 1'b1, 10'h040, 1'b0, 32'h0, pat(10'h040));
        step();
        d_req[2] = 1'b0; reset_n[2] = 1'b0;
        step();
        reset_n[2] = 1'b1;
        repeat (5) step();
        d_req[2] = 1'b1; d_addr[2] = 10'h041;
        exp_gnt(2, 1'b1, 10'h041, 1'b0, 32'h0, pat(10'h041));
        step();
        d_req[2] = 1'b0;
        repeat (5) step();

        final_req = 1'b1;
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
